operand_issue: RTL and testbench

- Issue stage directly downstream of the register bank.
- Drives the bank's two read addresses and consumes the combinational read values.
- Forces r0 to zero and bypasses the same-cycle writeback value, which the bank's sequential write port does not yet show.
- Tracks outstanding destination writes in a scoreboard, stalls on RAW/WAW hazards, and registers operands into a valid/ready pipeline register for execute.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/reg_scoreboard.sv | 47 ++++
 rtl/operand_issue.sv | 106 ++++++++++
 tb/tb_operand_issue.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and register-index helpers used by the issue stage.
package cpu_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  function automatic reg_mask_t onehot(input reg_idx_t idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Outstanding-destination scoreboard: one busy bit per architectural register.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     kill_en,
  input  reg_idx_t kill_idx,
  input  reg_idx_t look_rs,
  input  reg_idx_t look_ra,
  input  reg_idx_t look_rd,
  output logic     hit_rs,
  output logic     hit_ra,
  output logic     hit_rd
);

  reg_mask_t busy;
  reg_mask_t clr_vec;
  reg_mask_t set_vec;
  reg_mask_t kill_vec;
  reg_mask_t busy_eff;

  always_comb begin
    clr_vec  = (clr_en  && clr_idx  != REG_ZERO) ? onehot(clr_idx)  : '0;
    set_vec  = (set_en  && set_idx  != REG_ZERO) ? onehot(set_idx)  : '0;
    kill_vec = (kill_en && kill_idx != REG_ZERO) ? onehot(kill_idx) : '0;
    busy_eff = busy & ~clr_vec;
    hit_rs   = (look_rs != REG_ZERO) && busy_eff[look_rs];
    hit_ra   = (look_ra != REG_ZERO) && busy_eff[look_ra];
    hit_rd   = (look_rd != REG_ZERO) && busy_eff[look_rd];
  end

  // Set is OR-ed after the clear so a new writer beats the retiring older one;
  // a flush kill is applied last and overrides both.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= ((busy & ~clr_vec) | set_vec) & ~kill_vec;
    end
  end

endmodule

// File: rtl/operand_issue.sv
// Issue stage: resolves operands from the register bank with r0 and writeback
// bypass, stalls on scoreboard hazards, and registers the result for execute.
module operand_issue #(
  parameter int unsigned XLEN   = cpu_pkg::XLEN,
  parameter int unsigned CTRL_W = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] in_rs,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] in_ra,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] in_rd,
  input  logic                          in_writes_rd,
  input  logic [CTRL_W-1:0]             in_ctrl,
  input  logic [XLEN-1:0]               in_pc,
  output logic [cpu_pkg::REG_ADDR_W-1:0] rf_rs,
  output logic [cpu_pkg::REG_ADDR_W-1:0] rf_ra,
  input  logic [XLEN-1:0]               rf_rs_val,
  input  logic [XLEN-1:0]               rf_ra_val,
  input  logic                          wb_we,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] wb_ain,
  input  logic [XLEN-1:0]               wb_din,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_rs_val,
  output logic [XLEN-1:0]               out_ra_val,
  output logic [cpu_pkg::REG_ADDR_W-1:0] out_rd,
  output logic                          out_writes_rd,
  output logic [CTRL_W-1:0]             out_ctrl,
  output logic [XLEN-1:0]               out_pc
);

  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] ra_val;
  logic            hit_rs;
  logic            hit_ra;
  logic            hit_rd;
  logic            hazard;
  logic            accept;
  logic            set_en;
  logic            kill_en;

  assign rf_rs = in_rs;
  assign rf_ra = in_ra;

  // The bank's write port is sequential, so a same-cycle writeback must be
  // forwarded here; r0 takes priority over the bypass.
  always_comb begin
    rs_val = rf_rs_val;
    ra_val = rf_ra_val;
    if (in_rs == cpu_pkg::REG_ZERO)   rs_val = '0;
    else if (wb_we && wb_ain == in_rs) rs_val = wb_din;
    if (in_ra == cpu_pkg::REG_ZERO)   ra_val = '0;
    else if (wb_we && wb_ain == in_ra) ra_val = wb_din;
  end

  always_comb begin
    hazard   = in_valid && (hit_rs || hit_ra || (in_writes_rd && hit_rd));
    in_ready = !hazard && !flush && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
    set_en   = accept && in_writes_rd;
    kill_en  = flush && out_valid && out_writes_rd;
  end

  reg_scoreboard u_sb (
    .clock    (clock),
    .reset    (reset),
    .clr_en   (wb_we),
    .clr_idx  (wb_ain),
    .set_en   (set_en),
    .set_idx  (in_rd),
    .kill_en  (kill_en),
    .kill_idx (out_rd),
    .look_rs  (in_rs),
    .look_ra  (in_ra),
    .look_rd  (in_rd),
    .hit_rs   (hit_rs),
    .hit_ra   (hit_ra),
    .hit_rd   (hit_rd)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_rs_val    <= '0;
      out_ra_val    <= '0;
      out_rd        <= '0;
      out_writes_rd <= 1'b0;
      out_ctrl      <= '0;
      out_pc        <= '0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_rs_val    <= rs_val;
      out_ra_val    <= ra_val;
      out_rd        <= in_rd;
      out_writes_rd <= in_writes_rd;
      out_ctrl      <= in_ctrl;
      out_pc        <= in_pc;
    end else if (flush || out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue: driver queues expected issue results,
// a monitor compares them when execute accepts an entry.
module tb_operand_issue;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs;
  logic [4:0]  in_ra;
  logic [4:0]  in_rd;
  logic        in_writes_rd;
  logic [15:0] in_ctrl;
  logic [31:0] in_pc;
  logic [4:0]  rf_rs;
  logic [4:0]  rf_ra;
  logic [31:0] rf_rs_val;
  logic [31:0] rf_ra_val;
  logic        wb_we;
  logic [4:0]  wb_ain;
  logic [31:0] wb_din;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs_val;
  logic [31:0] out_ra_val;
  logic [4:0]  out_rd;
  logic        out_writes_rd;
  logic [15:0] out_ctrl;
  logic [31:0] out_pc;

  typedef struct {
    logic [31:0] rs_val;
    logic [31:0] ra_val;
    logic [4:0]  rd;
    logic        wr;
    logic [15:0] ctrl;
    logic [31:0] pc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] e_rs;
  logic [31:0] e_ra;
  int          errors = 0;
  int          checks = 0;

  operand_issue #(.XLEN(32), .CTRL_W(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rs         (in_rs),
    .in_ra         (in_ra),
    .in_rd         (in_rd),
    .in_writes_rd  (in_writes_rd),
    .in_ctrl       (in_ctrl),
    .in_pc         (in_pc),
    .rf_rs         (rf_rs),
    .rf_ra         (rf_ra),
    .rf_rs_val     (rf_rs_val),
    .rf_ra_val     (rf_ra_val),
    .wb_we         (wb_we),
    .wb_ain        (wb_ain),
    .wb_din        (wb_din),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rs_val    (out_rs_val),
    .out_ra_val    (out_ra_val),
    .out_rd        (out_rd),
    .out_writes_rd (out_writes_rd),
    .out_ctrl      (out_ctrl),
    .out_pc        (out_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Accepted instructions are recorded at mid-cycle, before the accepting edge.
  task automatic cycle();
    exp_t e;
    @(negedge clock);
    if (!reset && in_valid && in_ready) begin
      e.rs_val = e_rs;
      e.ra_val = e_ra;
      e.rd     = in_rd;
      e.wr     = in_writes_rd;
      e.ctrl   = in_ctrl;
      e.pc     = in_pc;
      q.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] ra, input logic [4:0] rd,
                       input logic wr, input logic [31:0] rsv, input logic [31:0] rav,
                       input logic [31:0] ers, input logic [31:0] era,
                       input logic [31:0] pc, input logic [15:0] ctrl);
    in_valid     = 1'b1;
    in_rs        = rs;
    in_ra        = ra;
    in_rd        = rd;
    in_writes_rd = wr;
    rf_rs_val    = rsv;
    rf_ra_val    = rav;
    e_rs         = ers;
    e_ra         = era;
    in_pc        = pc;
    in_ctrl      = ctrl;
  endtask

  // Monitor: compare each entry as execute takes it; flushed entries are dropped.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (!reset && out_valid) begin
        if (flush) begin
          if (q.size() > 0) void'(q.pop_front());
        end else if (out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: got pc 0x%0h expected no entry", out_pc);
          end else begin
            e = q.pop_front();
            chk("out_rs_val", 64'(out_rs_val), 64'(e.rs_val));
            chk("out_ra_val", 64'(out_ra_val), 64'(e.ra_val));
            chk("out_rd", 64'(out_rd), 64'(e.rd));
            chk("out_writes_rd", 64'(out_writes_rd), 64'(e.wr));
            chk("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
            chk("out_pc", 64'(out_pc), 64'(e.pc));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 0; in_rs = 0; in_ra = 0; in_rd = 0; in_writes_rd = 0;
    in_ctrl = 0; in_pc = 0; rf_rs_val = 0; rf_ra_val = 0; wb_we = 0; wb_ain = 0;
    wb_din = 0; flush = 0; out_ready = 1; e_rs = 0; e_ra = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_pc", 64'(out_pc), 64'd0);
    chk("reset_busy", 64'(dut.u_sb.busy), 64'd0);
    reset = 1'b0;

    // Bypass: bank still shows 0 for r5 while writeback writes it this cycle.
    issue(5, 6, 0, 0, 32'h0, 32'h66, 32'hDEADBEEF, 32'h66, 32'h100, 16'h11);
    wb_we = 1; wb_ain = 5; wb_din = 32'hDEADBEEF;
    #1;
    chk("rf_rs_addr", 64'(rf_rs), 64'd5);
    chk("rf_ra_addr", 64'(rf_ra), 64'd6);
    chk("bypass_ready", 64'(in_ready), 64'd1);
    cycle();
    wb_we = 0; in_valid = 0;
    cycle();

    // RAW stall on r7 until its writeback arrives.
    issue(1, 2, 7, 1, 32'h11, 32'h22, 32'h11, 32'h22, 32'h110, 16'h12);
    cycle();
    issue(3, 7, 8, 0, 32'h33, 32'h0, 32'h33, 32'h1234, 32'h114, 16'h13);
    #1;
    chk("raw_busy7", 64'(dut.u_sb.busy), 64'h80);
    for (int i = 0; i < 3; i++) begin
      chk("raw_stall", 64'(in_ready), 64'd0);
      cycle();
    end
    wb_we = 1; wb_ain = 7; wb_din = 32'h1234;
    #1;
    chk("raw_release", 64'(in_ready), 64'd1);
    cycle();
    wb_we = 0; in_valid = 0;
    #1;
    chk("raw_busy_clear", 64'(dut.u_sb.busy), 64'd0);
    cycle();

    // r0 reads as zero, ignores a bypass to r0 and is never marked busy.
    issue(0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h200, 16'h22);
    wb_we = 1; wb_ain = 0; wb_din = 32'hABCD;
    #1;
    chk("r0_ready", 64'(in_ready), 64'd1);
    cycle();
    wb_we = 0;
    issue(0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h204, 16'h23);
    #1;
    chk("r0_busy", 64'(dut.u_sb.busy), 64'd0);
    chk("r0_no_stall", 64'(in_ready), 64'd1);
    cycle();
    in_valid = 0;
    cycle();

    // Backpressure: held entry stays put and the next one waits.
    out_ready = 0;
    issue(1, 2, 10, 1, 32'hA1, 32'hA2, 32'hA1, 32'hA2, 32'h300, 16'h44);
    cycle();
    issue(4, 5, 11, 1, 32'hB4, 32'hB5, 32'hB4, 32'hB5, 32'h304, 16'h55);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_rs", 64'(out_rs_val), 64'hA1);
      chk("bp_out_pc", 64'(out_pc), 64'h300);
      chk("bp_busy", 64'(dut.u_sb.busy), 64'h400);
      cycle();
    end
    out_ready = 1;
    #1;
    chk("bp_release", 64'(in_ready), 64'd1);
    cycle();
    in_valid = 0;
    cycle();
    chk("bp_busy_two", 64'(dut.u_sb.busy), 64'hC00);
    wb_we = 1; wb_ain = 20; wb_din = 32'h0;
    cycle();
    chk("wb_not_busy", 64'(dut.u_sb.busy), 64'hC00);
    wb_ain = 10;
    cycle();
    wb_ain = 11;
    cycle();
    wb_we = 0;
    chk("bp_busy_drained", 64'(dut.u_sb.busy), 64'd0);

    // Flush kills the held r9 writer and frees r9.
    out_ready = 0;
    issue(1, 2, 9, 1, 32'h91, 32'h92, 32'h91, 32'h92, 32'h400, 16'h66);
    cycle();
    issue(9, 0, 0, 0, 32'h99, 32'h0, 32'h99, 32'h0, 32'h404, 16'h77);
    flush = 1;
    #1;
    chk("flush_ready", 64'(in_ready), 64'd0);
    chk("flush_out_rd", 64'(out_rd), 64'd9);
    chk("flush_busy9", 64'(dut.u_sb.busy), 64'h200);
    cycle();
    flush = 0;
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_busy_clear", 64'(dut.u_sb.busy), 64'd0);
    chk("flush_then_ready", 64'(in_ready), 64'd1);
    cycle();
    out_ready = 1; in_valid = 0;
    cycle();

    // WAW on r12 released by its own writeback; set beats the same-cycle clear.
    issue(0, 0, 3, 1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h500, 16'h1);
    cycle();
    issue(0, 0, 12, 1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h504, 16'h2);
    cycle();
    issue(0, 0, 12, 1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h508, 16'h3);
    #1;
    chk("waw_stall", 64'(in_ready), 64'd0);
    wb_we = 1; wb_ain = 12; wb_din = 32'h5;
    #1;
    chk("waw_release", 64'(in_ready), 64'd1);
    cycle();
    wb_we = 0; out_ready = 0;
    issue(1, 2, 13, 1, 32'h5, 32'h6, 32'h5, 32'h6, 32'h50C, 16'h4);
    #1;
    chk("set_wins_busy", 64'(dut.u_sb.busy), 64'h1008);
    chk("pre_reset_valid", 64'(out_valid), 64'd1);

    // Reset mid-operation with an instruction presented.
    reset = 1;
    cycle();
    q.delete();
    in_valid = 0; reset = 0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(dut.u_sb.busy), 64'd0);
    chk("rst_out_rs", 64'(out_rs_val), 64'd0);
    chk("rst_out_ra", 64'(out_ra_val), 64'd0);
    chk("rst_out_rd", 64'(out_rd), 64'd0);
    chk("rst_out_wr", 64'(out_writes_rd), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);

    out_ready = 1;
    repeat (2) cycle();
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
